// File: rtl/en_round_iter.sv
// Iterative AES-128 encryption datapath: initial AddRoundKey, then NR rounds, round keys fetched by index.
// Optional build macro AES_ROUND_SPLIT_EN splits each round over two cycles (SubBytes/ShiftRows, then MixColumns/AddRoundKey).
module en_round_iter #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iValid,
  output logic         oReady,
  input  logic [127:0] iBlockIn,
  output logic [3:0]   oKeyIdx,
  input  logic [127:0] iKeyValue,
  output logic         oValid,
  input  logic         iReady,
  output logic [127:0] oBlockout
);

  // Handshake: a block transfers on a cycle where valid && ready are both high;
  // a producer holds valid and data stable until that cycle.
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

  localparam logic [3:0] LAST_RND = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte k = row + 4*col lives at bits [127-8k -: 8]; ShiftRows pulls row r from column (c+r)%4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(row+4*c) -: 8] = SBOX[s[127-8*(row+4*((c+row)%4)) -: 8]];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] st_q, st_d;
  logic [127:0] out_q, out_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic         phase_q, phase_d;
  logic         round_end;
  logic [127:0] pre_mix;
  logic [127:0] rnd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    st_d      = st_q;
    out_d     = out_q;
    valid_d   = valid_q;
    phase_d   = 1'b0;
    oKeyIdx   = 4'd0;
    rnd       = '0;
`ifdef AES_ROUND_SPLIT_EN
    // Phase 0 has already stored ShiftRows(SubBytes(state)) in st_q when phase 1 runs.
    round_end = phase_q;
    pre_mix   = st_q;
`else
    round_end = 1'b1;
    pre_mix   = sub_shift(st_q);
`endif
    case (state_q)
      IDLE: begin
        if (iValid && ready_q) begin
          st_d    = iBlockIn ^ iKeyValue;
          cnt_d   = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        oKeyIdx = cnt_q;
        if (round_end) begin
          rnd  = ((cnt_q == LAST_RND) ? pre_mix : mix_cols(pre_mix)) ^ iKeyValue;
          st_d = rnd;
          if (cnt_q == LAST_RND) begin
            out_d   = rnd;
            valid_d = 1'b1;
            cnt_d   = 4'd0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          st_d    = sub_shift(st_q);
          phase_d = 1'b1;
        end
      end
      DONE: begin
        if (iReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready only from the second IDLE cycle on, so a completed block never overlaps an accept.
    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      st_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      phase_q <= phase_d;
    end
  end

  assign oReady    = ready_q;
  assign oValid    = valid_q;
  assign oBlockout = out_q;

endmodule

// File: tb/tb_en_round_iter.sv
// Bench for en_round_iter: FIPS-197 vectors, backpressure, mid-run reset, back-to-back and random blocks
// checked against a byte-level AES reference model with its own S-box derived from GF(2^8) inversion.
module tb_en_round_iter;

`ifdef AES_ROUND_SPLIT_EN
  localparam int PH = 2;
`else
  localparam int PH = 1;
`endif
  localparam int LAT = 1 + 10 * PH;

  logic         clk = 1'b0;
  logic         rst;
  logic         iValid;
  logic         oReady;
  logic [127:0] iBlockIn;
  logic [3:0]   oKeyIdx;
  logic [127:0] iKeyValue;
  logic         oValid;
  logic         iReady;
  logic [127:0] oBlockout;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] exp_q[$];
  logic [127:0] rk_mem [11];
  logic [7:0]   sb [256];

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  en_round_iter dut (
    .clk       (clk),
    .rst       (rst),
    .iValid    (iValid),
    .oReady    (oReady),
    .iBlockIn  (iBlockIn),
    .oKeyIdx   (oKeyIdx),
    .iKeyValue (iKeyValue),
    .oValid    (oValid),
    .iReady    (iReady),
    .oBlockout (oBlockout)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // external key-schedule store, combinational read
  always_comb begin
    iKeyValue = '0;
    if (oKeyIdx <= 4'd10) iKeyValue = rk_mem[oKeyIdx];
  end

  // reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, cst;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb[x] = s;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k, res;
    for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) st[i] = sb[st[i]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) tmp[r+4*c] = st[r+4*((c+r)%4)];
        st = tmp;
        if (rnd < 10) begin
          for (int c = 0; c < 4; c++) begin
            a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
            st[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
            st[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
            st[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
            st[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
          end
        end
      end
      k = rk_mem[rnd];
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ k[127-8*i -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
    return res;
  endfunction

  // scoreboard / comparison
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    chk(tag, {127'b0, obs}, {127'b0, exp});
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    chk(tag, {96'b0, 32'(obs)}, {96'b0, 32'(exp)});
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input string tag, input logic [127:0] pt, input logic [127:0] exp);
    int n;
    n = 0;
    while (oReady !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk_b({tag, "_ready"}, oReady, 1'b1);
    chk({tag, "_keyidx0"}, {124'b0, oKeyIdx}, 128'd0);
    iValid   = 1'b1;
    iBlockIn = pt;
    exp_q.push_back(exp);
    tick();
    iValid   = 1'b0;
  endtask

  // Walks the round cycles: key index per cycle, no early oValid, inputs scrambled meanwhile.
  task automatic rounds(input string tag);
    for (int r = 1; r <= 10; r++) begin
      for (int p = 0; p < PH; p++) begin
        chk({tag, "_keyidx"}, {124'b0, oKeyIdx}, 128'(r));
        chk_b({tag, "_early_valid"}, oValid, 1'b0);
        chk_b({tag, "_busy_ready"}, oReady, 1'b0);
        iBlockIn = rand128();
        iValid   = 1'($urandom_range(0, 1));
        tick();
      end
    end
    iValid = 1'b0;
    chk_b({tag, "_latency_valid"}, oValid, 1'b1);
  endtask

  task automatic take(input string tag);
    logic [127:0] e;
    e = '0;
    if (exp_q.size() == 0) chk_i({tag, "_sb_empty"}, 0, 1);
    else e = exp_q.pop_front();
    chk({tag, "_data"}, oBlockout, e);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    chk_b({tag, "_valid_drop"}, oValid, 1'b0);
    chk_b({tag, "_ready_gap"}, oReady, 1'b0);
    tick();
    chk_b({tag, "_ready_back"}, oReady, 1'b1);
  endtask

  initial begin
    logic [127:0] pts [3];
    logic [127:0] pt, ct;
    int acc_t [3];
    int k, got, cyc;

    rst = 1'b1; iValid = 1'b0; iReady = 1'b0; iBlockIn = '0;
    for (int r = 0; r < 11; r++) rk_mem[r] = '0;
    build_sbox();

    // reset state
    repeat (3) tick();
    chk_b("rst_ready", oReady, 1'b0);
    chk_b("rst_valid", oValid, 1'b0);
    chk("rst_block", oBlockout, 128'd0);
    chk("rst_keyidx", {124'b0, oKeyIdx}, 128'd0);
    rst = 1'b0;
    tick();
    chk_b("post_rst_ready", oReady, 1'b1);

    // FIPS-197 App. B
    expand_key(KEY_B);
    send("appB", PT_B, CT_B);
    rounds("appB");
    take("appB");

    // FIPS-197 App. C.1 with key index sequencing and input scrambling during rounds
    expand_key(KEY_C);
    send("appC", PT_C, CT_C);
    rounds("appC");
    take("appC");

    // backpressure: result held 5 cycles, stray iValid ignored
    expand_key(KEY_B);
    send("bp", PT_B, CT_B);
    rounds("bp");
    for (int i = 0; i < 5; i++) begin
      chk_b("bp_hold_valid", oValid, 1'b1);
      chk("bp_hold_data", oBlockout, CT_B);
      chk_b("bp_hold_ready", oReady, 1'b0);
      iValid   = (i == 2);
      iBlockIn = rand128();
      tick();
    end
    iValid = 1'b0;
    take("bp");

    // reset in round 5
    send("midrst", PT_B, CT_B);
    repeat (4 * PH) tick();
    chk("midrst_at_round5", {124'b0, oKeyIdx}, 128'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk_b("midrst_valid", oValid, 1'b0);
    chk("midrst_block", oBlockout, 128'd0);
    chk_b("midrst_ready", oReady, 1'b0);
    tick();
    chk_b("midrst_ready_back", oReady, 1'b1);
    send("after_rst", PT_B, CT_B);
    rounds("after_rst");
    take("after_rst");

    // back-to-back with iValid and iReady held high
    pts[0] = PT_B; pts[1] = rand128(); pts[2] = rand128();
    k = 0; got = 0; cyc = 0;
    acc_t[0] = 0; acc_t[1] = 0; acc_t[2] = 0;
    iReady = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (k < 3) begin
        iValid   = 1'b1;
        iBlockIn = pts[k];
        if (oReady === 1'b1) begin
          acc_t[k] = cyc;
          exp_q.push_back(ref_encrypt(pts[k]));
          k++;
        end
      end else begin
        iValid = 1'b0;
      end
      if (oValid === 1'b1) begin
        if (exp_q.size() == 0) chk_i("b2b_sb_empty", 0, 1);
        else chk("b2b_data", oBlockout, exp_q.pop_front());
        got++;
      end
      tick();
      cyc++;
    end
    iValid = 1'b0;
    iReady = 1'b0;
    chk_i("b2b_count", got, 3);
    chk_i("b2b_spacing01", acc_t[1] - acc_t[0], LAT + 2);
    chk_i("b2b_spacing12", acc_t[2] - acc_t[1], LAT + 2);

    // random keys and plaintexts against the reference model
    for (int t = 0; t < 4; t++) begin
      expand_key(rand128());
      pt = rand128();
      ct = ref_encrypt(pt);
      send("rand", pt, ct);
      rounds("rand");
      take("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
